// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the mux select controller.
// The state encoding is also used by the testbench-facing debug view.
package mux_sel_pkg;

  // Controller states: IDLE accepts requests; GAP holds out_en low before
  // the select moves; SWAP re-enables the output; DWELL blocks new requests.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_SWAP  = 2'd2,
    ST_DWELL = 2'd3
  } state_e;

  // Default width of sel / req_sel.
  localparam int DEF_SEL_W = 2;

  // Width of the completed-switch counter port.
  localparam int SWITCH_CNT_W = 16;

endpackage : mux_sel_pkg

// File: rtl/mux_sel_timer.sv
// Loadable down-counter shared by the GAP and DWELL phases of
// mux_sel_ctrl. A load takes priority over a decrement; the counter
// holds at zero rather than wrapping.
module mux_sel_timer
  import mux_sel_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement toward zero when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule : mux_sel_timer

// File: rtl/mux_sel_ctrl.sv
// Break-before-make select controller for a downstream data mux.
// A switch request drops out_en, waits GAP cycles, moves sel, re-enables
// the output for one SWAP cycle transition, then blocks new requests for
// MIN_DWELL cycles. Same-select requests complete immediately with done;
// out-of-range requests complete immediately with err.
// Optional feature macro: MUX_SEL_CTRL_STATS_EN enables the saturating
// switch_cnt counter; when undefined switch_cnt is tied to zero.
module mux_sel_ctrl
  import mux_sel_pkg::*;
#(
  parameter int NUM_IN    = 2,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int GAP       = 2,
  parameter int MIN_DWELL = 4,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic [SEL_W-1:0]        req_sel,
  output logic                    req_ready,
  output logic [SEL_W-1:0]        sel,
  output logic                    out_en,
  output logic                    done,
  output logic                    err,
  output logic                    busy,
  output logic [SWITCH_CNT_W-1:0] switch_cnt
);

  // Counter reload values; GAP is at least one so GAP-1 never underflows.
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] DWELL_LD = (MIN_DWELL > 0) ? CNT_W'(MIN_DWELL - 1) : '0;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] pend_q, pend_d;
  logic             out_en_q, out_en_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;

  logic             req_illegal;
  logic             accept;

  // Ready is a pure decode of the state register, so there is no
  // combinational path from req_valid to req_ready.
  assign req_ready   = (state_q == ST_IDLE);
  assign accept      = req_valid && req_ready;
  assign req_illegal = (32'(req_sel) >= NUM_IN);

  mux_sel_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .dec     (tmr_dec),
    .zero    (tmr_zero)
  );

  // Next-state, select and pulse generation for the switch sequence.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    pend_d   = pend_q;
    out_en_d = out_en_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_illegal) begin
            // Out-of-range index: reject without touching the mux.
            err_d = 1'b1;
          end else if (req_sel == sel_q) begin
            // Already selected: complete immediately, output stays enabled.
            done_d = 1'b1;
          end else begin
            // Real switch: latch the target and start the break phase.
            pend_d   = req_sel;
            out_en_d = 1'b0;
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
          end
        end
      end

      ST_GAP: begin
        if (tmr_zero) begin
          // Output has been quiet long enough; move the select now.
          sel_d   = pend_q;
          state_d = ST_SWAP;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_SWAP: begin
        // Select has settled for one cycle; re-enable and report completion.
        out_en_d = 1'b1;
        done_d   = 1'b1;
        if (MIN_DWELL > 0) begin
          state_d  = ST_DWELL;
          tmr_load = 1'b1;
          tmr_val  = DWELL_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DWELL: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        out_en_d = 1'b1;
      end
    endcase
  end

  // Control and select registers; reset abandons any in-flight switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      pend_q   <= '0;
      out_en_q <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      pend_q   <= pend_d;
      out_en_q <= out_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign sel    = sel_q;
  assign out_en = out_en_q;
  assign done   = done_q;
  assign err    = err_q;
  assign busy   = (state_q != ST_IDLE);

`ifdef MUX_SEL_CTRL_STATS_EN
  logic [SWITCH_CNT_W-1:0] switch_cnt_q;
  logic [SWITCH_CNT_W-1:0] switch_cnt_d;

  // Count completed switches (the SWAP cycle only), saturating at all-ones.
  always_comb begin
    switch_cnt_d = switch_cnt_q;
    if ((state_q == ST_SWAP) && (switch_cnt_q != '1)) begin
      switch_cnt_d = switch_cnt_q + SWITCH_CNT_W'(1);
    end
  end

  // Switch counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch_cnt_q <= '0;
    end else begin
      switch_cnt_q <= switch_cnt_d;
    end
  end

  assign switch_cnt = switch_cnt_q;
`else
  assign switch_cnt = '0;
`endif

endmodule : mux_sel_ctrl

// File: tb/tb_mux_sel_ctrl.sv
// Self-checking bench for mux_sel_ctrl (GAP=2, MIN_DWELL=4).
module tb_mux_sel_ctrl;

  localparam int NUM_IN    = 2;
  localparam int SEL_W     = 2;
  localparam int GAP       = 2;
  localparam int MIN_DWELL = 4;
  localparam int CNT_W     = 8;
  localparam int SW_LAT    = GAP + 1 + MIN_DWELL;
`ifdef MUX_SEL_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic [SEL_W-1:0] req_sel;
  logic             req_ready;
  logic [SEL_W-1:0] sel;
  logic             out_en;
  logic             done;
  logic             err;
  logic             busy;
  logic [15:0]      switch_cnt;

  mux_sel_ctrl #(
    .NUM_IN   (NUM_IN),
    .SEL_W    (SEL_W),
    .GAP      (GAP),
    .MIN_DWELL(MIN_DWELL),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .sel       (sel),
    .out_en    (out_en),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .switch_cnt(switch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  typedef struct {
    logic             is_err;
    logic [SEL_W-1:0] sel;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [SEL_W-1:0] req;
    logic [SEL_W-1:0] exp_sel;
    logic             exp_err;
    logic             sw;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 1);
  endtask

  // Issue one request, record its expected completion, return cycles until ready.
  task automatic run_req(input logic [SEL_W-1:0] s, input logic e_err,
                         input logic [SEL_W-1:0] e_sel, input logic sw, output int n);
    wait_ready();
    req_valid = 1'b1;
    req_sel   = s;
    sb_q.push_back(exp_t'{e_err, e_sel});
    if (sw) exp_cnt++;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Scoreboard consumer plus break-before-make invariant.
  logic [SEL_W-1:0] prev_sel;
  logic             prev_oe;
  always @(negedge clk) begin
    if (rst_n) begin
      if (done || err) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_pulse", 32'(sb_q.size()), 1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_err", 32'(err), 32'(e.is_err));
          chk("sb_done", 32'(done), 32'(!e.is_err));
          chk("sb_sel", 32'(sel), 32'(e.sel));
        end
      end
      if (sel !== prev_sel) chk("sel_change_with_out_en", 32'(prev_oe | out_en), 0);
    end
    prev_sel = sel;
    prev_oe  = out_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{2'd1, 2'd1, 1'b0, 1'b0};
    vecs[1] = '{2'd0, 2'd0, 1'b0, 1'b1};
    vecs[2] = '{2'd0, 2'd0, 1'b0, 1'b0};
    vecs[3] = '{2'd2, 2'd0, 1'b1, 1'b0};
    vecs[4] = '{2'd3, 2'd0, 1'b1, 1'b0};
    vecs[5] = '{2'd1, 2'd1, 1'b0, 1'b1};
    vecs[6] = '{2'd3, 2'd1, 1'b1, 1'b0};
    vecs[7] = '{2'd0, 2'd0, 1'b0, 1'b1};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_sel   = '0;
    repeat (2) tick();
    chk("rst_sel", 32'(sel), 0);
    chk("rst_out_en", 32'(out_en), 1);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done_err", 32'({done, err}), 0);
    chk("rst_cnt", 32'(switch_cnt), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_ready", 32'(req_ready), 1);
    chk("post_rst_out_en", 32'(out_en), 1);
    chk("post_rst_done_err", 32'({done, err}), 0);

    // First switch 0->1 with cycle-exact checks.
    req_valid = 1'b1;
    req_sel   = 2'd1;
    sb_q.push_back(exp_t'{1'b0, 2'd1});
    exp_cnt++;
    tick();                                     // edge T
    req_valid = 1'b0;
    chk("t0_out_en", 32'(out_en), 0);
    chk("t0_sel", 32'(sel), 0);
    chk("t0_ready", 32'(req_ready), 0);
    chk("t0_busy", 32'(busy), 1);
    tick();                                     // T+1
    chk("t1_out_en", 32'(out_en), 0);
    chk("t1_sel", 32'(sel), 0);
    tick();                                     // T+2
    chk("t2_out_en", 32'(out_en), 0);
    chk("t2_sel", 32'(sel), 1);
    tick();                                     // T+3
    chk("t3_out_en", 32'(out_en), 1);
    chk("t3_done", 32'(done), 1);
    for (int k = 4; k < SW_LAT; k++) begin
      tick();
      chk("dwell_ready_low", 32'(req_ready), 0);
      chk("dwell_done_low", 32'(done), 0);
    end
    tick();                                     // T+7
    chk("t7_ready", 32'(req_ready), 1);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_cnt", 32'(switch_cnt), STATS ? 32'(exp_cnt) : 0);

    // Table of single requests.
    for (int i = 0; i < 8; i++) begin
      run_req(vecs[i].req, vecs[i].exp_err, vecs[i].exp_sel, vecs[i].sw, n);
      chk("vec_latency", 32'(n), vecs[i].sw ? 32'(SW_LAT) : 0);
      chk("vec_sel", 32'(sel), 32'(vecs[i].exp_sel));
      chk("vec_out_en", 32'(out_en), 1);
      chk("vec_cnt", 32'(switch_cnt), STATS ? 32'(exp_cnt) : 0);
    end

    // req_valid held with changing req_sel through GAP/SWAP/DWELL.
    wait_ready();
    req_valid = 1'b1;
    req_sel   = 2'd1;
    sb_q.push_back(exp_t'{1'b0, 2'd1});
    exp_cnt++;
    tick();                                     // edge T
    for (int k = 0; k < SW_LAT; k++) begin
      chk("held_no_accept", 32'(req_ready), 0);
      req_sel = k[0] ? 2'd0 : 2'd1;
      tick();
    end
    chk("held_ready", 32'(req_ready), 1);
    chk("held_sel", 32'(sel), 1);
    req_sel = 2'd0;
    sb_q.push_back(exp_t'{1'b0, 2'd0});
    exp_cnt++;
    tick();                                     // accept of value present now
    req_valid = 1'b0;
    chk("held_accept_busy", 32'(busy), 1);
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    chk("held_latency", 32'(n), SW_LAT);
    chk("held_final_sel", 32'(sel), 0);

    // Reset in the middle of GAP while sel=1.
    run_req(2'd1, 1'b0, 2'd1, 1'b1, n);
    chk("pre_rst_sel", 32'(sel), 1);
    req_valid = 1'b1;
    req_sel   = 2'd0;
    tick();                                     // edge T
    req_valid = 1'b0;
    tick();                                     // T+1, in GAP
    chk("gap_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_sel", 32'(sel), 0);
    chk("async_rst_out_en", 32'(out_en), 1);
    chk("async_rst_ready", 32'(req_ready), 1);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_cnt", 32'(switch_cnt), 0);
    exp_cnt = 0;
    tick();
    rst_n = 1'b1;
    tick();
    run_req(2'd1, 1'b0, 2'd1, 1'b1, n);
    chk("post_rst_latency", 32'(n), SW_LAT);
    chk("post_rst_sel", 32'(sel), 1);
    chk("post_rst_cnt", 32'(switch_cnt), STATS ? 32'(exp_cnt) : 0);

    repeat (3) tick();
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux_sel_ctrl
